// File: rtl/sdram_ch2_wbuf.sv
// Posted-write buffer and read sequencer for SDRAM controller channel 2.
// Queues and merges CPU/DMA writes and drains them ahead of any pending read.
module sdram_ch2_wbuf #(
   parameter int unsigned DEPTH    = 4,
   parameter bit          MERGE_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_wr,
   input  logic [26:0] cpu_wr_addr,
   input  logic [31:0] cpu_wr_data,
   input  logic [3:0]  cpu_wr_be,
   output logic        cpu_full,
   output logic        cpu_wr_ovf,
   input  logic        cpu_rd,
   input  logic [26:0] cpu_rd_addr,
   output logic [31:0] cpu_rd_data,
   output logic        cpu_rd_done,
   output logic        cpu_busy,
   output logic        idle,
   output logic [26:0] ch2_addr,
   output logic [31:0] ch2_din,
   output logic [3:0]  ch2_be,
   output logic        ch2_rnw,
   output logic        ch2_req,
   input  logic        ch2_ready,
   input  logic [31:0] ch2_dout
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_WR_WAIT, S_RD_WAIT} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [24:0]     addr_q [DEPTH];
   logic [24:0]     addr_d [DEPTH];
   logic [31:0]     data_q [DEPTH];
   logic [31:0]     data_d [DEPTH];
   logic [3:0]      be_q   [DEPTH];
   logic [3:0]      be_d   [DEPTH];
   logic            pend_q, pend_d;
   logic [24:0]     rd_addr_q, rd_addr_d;

   logic            cpu_full_q, cpu_full_d;
   logic            cpu_wr_ovf_q, cpu_wr_ovf_d;
   logic [31:0]     cpu_rd_data_q, cpu_rd_data_d;
   logic            cpu_rd_done_q, cpu_rd_done_d;
   logic            cpu_busy_q, cpu_busy_d;
   logic            idle_q, idle_d;
   logic [26:0]     ch2_addr_q, ch2_addr_d;
   logic [31:0]     ch2_din_q, ch2_din_d;
   logic [3:0]      ch2_be_q, ch2_be_d;
   logic            ch2_rnw_q, ch2_rnw_d;
   logic            ch2_req_q, ch2_req_d;

   logic [AW-1:0]   newest;
   logic            head_issued;
   logic            merge;
   logic            full;
   logic            push;
   logic            pop;

   logic unused_ok;
   assign unused_ok = ^{cpu_wr_addr[1:0], cpu_rd_addr[1:0]};

   always_comb begin
      newest      = tail_q - AW'(1);
      // A lone entry in IDLE is being issued this cycle, so it is as untouchable as one in flight.
      head_issued = (count_q == CW'(1)) && (state_q != S_RD_WAIT);
      merge       = MERGE_EN && cpu_wr && (count_q != CW'(0)) && !head_issued &&
                    (addr_q[newest] == cpu_wr_addr[26:2]);
      full        = (count_q == CW'(DEPTH));
      push        = cpu_wr && !merge && !full;
      pop         = (state_q == S_WR_WAIT) && ch2_ready;

      state_d       = state_q;
      head_d        = head_q;
      tail_d        = tail_q;
      addr_d        = addr_q;
      data_d        = data_q;
      be_d          = be_q;
      pend_d        = pend_q;
      rd_addr_d     = rd_addr_q;
      cpu_rd_data_d = cpu_rd_data_q;
      cpu_rd_done_d = 1'b0;
      cpu_wr_ovf_d  = cpu_wr && !merge && full;
      ch2_addr_d    = ch2_addr_q;
      ch2_din_d     = ch2_din_q;
      ch2_be_d      = ch2_be_q;
      ch2_rnw_d     = ch2_rnw_q;
      ch2_req_d     = 1'b0;

      if (push) begin
         addr_d[tail_q] = cpu_wr_addr[26:2];
         data_d[tail_q] = cpu_wr_data;
         be_d[tail_q]   = cpu_wr_be;
         tail_d         = tail_q + AW'(1);
      end

      if (merge) begin
         for (int i = 0; i < 4; i++) begin
            if (cpu_wr_be[i]) begin
               data_d[newest][8*i +: 8] = cpu_wr_data[8*i +: 8];
            end
         end
         be_d[newest] = be_q[newest] | cpu_wr_be;
      end

      if (pop) begin
         head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      if (cpu_rd && !pend_q) begin
         pend_d    = 1'b1;
         rd_addr_d = cpu_rd_addr[26:2];
      end

      case (state_q)
         S_IDLE: begin
            if (count_q != CW'(0)) begin
               ch2_addr_d = {addr_q[head_q], 2'b00};
               ch2_din_d  = data_q[head_q];
               ch2_be_d   = be_q[head_q];
               ch2_rnw_d  = 1'b0;
               ch2_req_d  = 1'b1;
               state_d    = S_WR_WAIT;
            end else if (pend_q) begin
               ch2_addr_d = {rd_addr_q, 2'b00};
               ch2_be_d   = 4'hF;
               ch2_rnw_d  = 1'b1;
               ch2_req_d  = 1'b1;
               state_d    = S_RD_WAIT;
            end
         end
         S_WR_WAIT: begin
            if (ch2_ready) begin
               state_d = S_IDLE;
            end
         end
         S_RD_WAIT: begin
            if (ch2_ready) begin
               cpu_rd_data_d = ch2_dout;
               cpu_rd_done_d = 1'b1;
               pend_d        = 1'b0;
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      cpu_full_d = (count_d == CW'(DEPTH));
      cpu_busy_d = pend_d || (state_d == S_RD_WAIT);
      idle_d     = (count_d == CW'(0)) && !pend_d && (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
         end
         pend_q        <= 1'b0;
         rd_addr_q     <= '0;
         cpu_full_q    <= 1'b0;
         cpu_wr_ovf_q  <= 1'b0;
         cpu_rd_data_q <= '0;
         cpu_rd_done_q <= 1'b0;
         cpu_busy_q    <= 1'b0;
         idle_q        <= 1'b1;
         ch2_addr_q    <= '0;
         ch2_din_q     <= '0;
         ch2_be_q      <= 4'hF;
         ch2_rnw_q     <= 1'b0;
         ch2_req_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         be_q          <= be_d;
         pend_q        <= pend_d;
         rd_addr_q     <= rd_addr_d;
         cpu_full_q    <= cpu_full_d;
         cpu_wr_ovf_q  <= cpu_wr_ovf_d;
         cpu_rd_data_q <= cpu_rd_data_d;
         cpu_rd_done_q <= cpu_rd_done_d;
         cpu_busy_q    <= cpu_busy_d;
         idle_q        <= idle_d;
         ch2_addr_q    <= ch2_addr_d;
         ch2_din_q     <= ch2_din_d;
         ch2_be_q      <= ch2_be_d;
         ch2_rnw_q     <= ch2_rnw_d;
         ch2_req_q     <= ch2_req_d;
      end
   end

   assign cpu_full    = cpu_full_q;
   assign cpu_wr_ovf  = cpu_wr_ovf_q;
   assign cpu_rd_data = cpu_rd_data_q;
   assign cpu_rd_done = cpu_rd_done_q;
   assign cpu_busy    = cpu_busy_q;
   assign idle        = idle_q;
   assign ch2_addr    = ch2_addr_q;
   assign ch2_din     = ch2_din_q;
   assign ch2_be      = ch2_be_q;
   assign ch2_rnw     = ch2_rnw_q;
   assign ch2_req     = ch2_req_q;

endmodule

// File: tb/tb_sdram_ch2_wbuf.sv
// Directed bench for sdram_ch2_wbuf: write drain, merge, overflow, read ordering,
// simultaneous push/pop and reset mid-operation.
module tb_sdram_ch2_wbuf;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_wr;
   logic [26:0] cpu_wr_addr;
   logic [31:0] cpu_wr_data;
   logic [3:0]  cpu_wr_be;
   logic        cpu_full;
   logic        cpu_wr_ovf;
   logic        cpu_rd;
   logic [26:0] cpu_rd_addr;
   logic [31:0] cpu_rd_data;
   logic        cpu_rd_done;
   logic        cpu_busy;
   logic        idle;
   logic [26:0] ch2_addr;
   logic [31:0] ch2_din;
   logic [3:0]  ch2_be;
   logic        ch2_rnw;
   logic        ch2_req;
   logic        ch2_ready;
   logic [31:0] ch2_dout;

   int n_assert = 0;
   int n_fail   = 0;

   sdram_ch2_wbuf #(.DEPTH(4), .MERGE_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .cpu_wr(cpu_wr), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
      .cpu_wr_be(cpu_wr_be), .cpu_full(cpu_full), .cpu_wr_ovf(cpu_wr_ovf),
      .cpu_rd(cpu_rd), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_data(cpu_rd_data),
      .cpu_rd_done(cpu_rd_done), .cpu_busy(cpu_busy), .idle(idle),
      .ch2_addr(ch2_addr), .ch2_din(ch2_din), .ch2_be(ch2_be), .ch2_rnw(ch2_rnw),
      .ch2_req(ch2_req), .ch2_ready(ch2_ready), .ch2_dout(ch2_dout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cpu_wr = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0; cpu_wr_be = '0;
      cpu_rd = 1'b0; cpu_rd_addr = '0; ch2_ready = 1'b0; ch2_dout = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push(input logic [26:0] a, input logic [31:0] d, input logic [3:0] be);
      cpu_wr = 1'b1; cpu_wr_addr = a; cpu_wr_data = d; cpu_wr_be = be;
      tick();
      cpu_wr = 1'b0;
   endtask

   task automatic give_ready(input logic [31:0] d);
      ch2_ready = 1'b1; ch2_dout = d;
      tick();
      ch2_ready = 1'b0; ch2_dout = '0;
   endtask

   task automatic wait_req(input string tag, input int max_cyc);
      logic seen_low;
      int   n;
      seen_low = (ch2_req === 1'b0);
      n = 0;
      while (ch2_req !== 1'b1 && n < max_cyc) begin
         tick();
         n++;
      end
      check({tag, "_req"}, 32'(ch2_req), 32'd1);
      check({tag, "_low_before"}, 32'(seen_low), 32'd1);
   endtask

   initial begin
      // Reset state
      do_reset();
      reset = 1'b1;
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_be", 32'(ch2_be), 32'hF);
      check("rst_req", 32'(ch2_req), 32'd0);
      check("rst_full", 32'(cpu_full), 32'd0);
      check("rst_busy", 32'(cpu_busy), 32'd0);
      check("rst_addr", 32'(ch2_addr), 32'd0);
      reset = 1'b0;

      // Single write
      push(27'h0000104, 32'hDEADBEEF, 4'hF);
      wait_req("w1", 4);
      check("w1_addr", 32'(ch2_addr), 32'h104);
      check("w1_rnw", 32'(ch2_rnw), 32'd0);
      check("w1_din", ch2_din, 32'hDEADBEEF);
      tick();
      check("w1_req_pulse", 32'(ch2_req), 32'd0);
      repeat (6) tick();
      check("w1_busy_idle", 32'(idle), 32'd0);
      give_ready(32'h0);
      check("w1_idle", 32'(idle), 32'd1);
      tick();
      check("w1_no_req", 32'(ch2_req), 32'd0);

      // Merge
      do_reset();
      push(27'h0000200, 32'h11223344, 4'h3);
      push(27'h0000300, 32'hAABBCCDD, 4'hF);
      check("m_req0", 32'(ch2_req), 32'd1);
      check("m_addr0", 32'(ch2_addr), 32'h200);
      push(27'h0000302, 32'h55667788, 4'hC);
      check("m_count", 32'(dut.count_q), 32'd2);
      check("m_data", dut.data_q[1], 32'h5566CCDD);
      check("m_be", 32'(dut.be_q[1]), 32'hF);
      check("m_be0", 32'(ch2_be), 32'h3);
      give_ready(32'h0);
      wait_req("m2", 4);
      check("m2_addr", 32'(ch2_addr), 32'h300);
      check("m2_din", ch2_din, 32'h5566CCDD);
      check("m2_be", 32'(ch2_be), 32'hF);
      give_ready(32'h0);
      check("m_idle", 32'(idle), 32'd1);

      // Full / overflow
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(27'h0001000 + 27'(4 * i), 32'h10000000 + 32'(i), 4'hF);
         check("f_full_step", 32'(cpu_full), (i == 3) ? 32'd1 : 32'd0);
      end
      push(27'h0001010, 32'h10000004, 4'hF);
      check("f_ovf", 32'(cpu_wr_ovf), 32'd1);
      check("f_count", 32'(dut.count_q), 32'd4);
      check("f_full", 32'(cpu_full), 32'd1);
      tick();
      check("f_ovf_pulse", 32'(cpu_wr_ovf), 32'd0);
      check("f_addr0", 32'(ch2_addr), 32'h1000);
      check("f_din0", ch2_din, 32'h10000000);
      give_ready(32'h0);
      for (int i = 1; i < 4; i++) begin
         wait_req("f_drain", 4);
         check("f_addr", 32'(ch2_addr), 32'h1000 + 32'(4 * i));
         check("f_din", ch2_din, 32'h10000000 + 32'(i));
         give_ready(32'h0);
      end
      check("f_idle", 32'(idle), 32'd1);
      check("f_full_clr", 32'(cpu_full), 32'd0);

      // Read-after-write ordering
      do_reset();
      push(27'h0000500, 32'hA0A0A0A0, 4'hF);
      push(27'h0000504, 32'hB0B0B0B0, 4'hF);
      cpu_rd = 1'b1; cpu_rd_addr = 27'h0000400;
      tick();
      cpu_rd_addr = 27'h0000800;
      tick();
      cpu_rd = 1'b0;
      check("r_busy", 32'(cpu_busy), 32'd1);
      check("r_addr_w0", 32'(ch2_addr), 32'h500);
      give_ready(32'h0);
      wait_req("r_w1", 4);
      check("r_w1_rnw", 32'(ch2_rnw), 32'd0);
      check("r_w1_addr", 32'(ch2_addr), 32'h504);
      give_ready(32'h0);
      wait_req("r_rd", 4);
      check("r_rd_rnw", 32'(ch2_rnw), 32'd1);
      check("r_rd_addr", 32'(ch2_addr), 32'h400);
      check("r_rd_be", 32'(ch2_be), 32'hF);
      repeat (2) tick();
      check("r_done_early", 32'(cpu_rd_done), 32'd0);
      give_ready(32'hCAFEF00D);
      check("r_done", 32'(cpu_rd_done), 32'd1);
      check("r_data", cpu_rd_data, 32'hCAFEF00D);
      check("r_busy_clr", 32'(cpu_busy), 32'd0);
      check("r_idle", 32'(idle), 32'd1);
      tick();
      check("r_done_pulse", 32'(cpu_rd_done), 32'd0);
      check("r_data_held", cpu_rd_data, 32'hCAFEF00D);

      // Simultaneous push and pop
      do_reset();
      push(27'h0000600, 32'h66000000, 4'hF);
      push(27'h0000604, 32'h66000004, 4'hF);
      check("s_count0", 32'(dut.count_q), 32'd2);
      cpu_wr = 1'b1; cpu_wr_addr = 27'h0000608; cpu_wr_data = 32'h66000008; cpu_wr_be = 4'hF;
      ch2_ready = 1'b1;
      tick();
      cpu_wr = 1'b0; ch2_ready = 1'b0;
      check("s_count", 32'(dut.count_q), 32'd2);
      check("s_tail_addr", 32'(dut.addr_q[2]), 32'h182);
      check("s_tail_data", dut.data_q[2], 32'h66000008);
      wait_req("s_w1", 4);
      check("s_w1_addr", 32'(ch2_addr), 32'h604);
      give_ready(32'h0);
      wait_req("s_w2", 4);
      check("s_w2_addr", 32'(ch2_addr), 32'h608);
      check("s_w2_din", ch2_din, 32'h66000008);
      give_ready(32'h0);
      check("s_idle", 32'(idle), 32'd1);

      // Reset mid-operation
      do_reset();
      push(27'h0000700, 32'h77000000, 4'hF);
      push(27'h0000704, 32'h77000004, 4'hF);
      push(27'h0000708, 32'h77000008, 4'hF);
      check("x_count3", 32'(dut.count_q), 32'd3);
      check("x_inflight", 32'(ch2_addr), 32'h700);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("x_count0", 32'(dut.count_q), 32'd0);
      check("x_idle", 32'(idle), 32'd1);
      check("x_req", 32'(ch2_req), 32'd0);
      give_ready(32'h12345678);
      check("x_stray_count", 32'(dut.count_q), 32'd0);
      check("x_stray_done", 32'(cpu_rd_done), 32'd0);
      check("x_stray_data", cpu_rd_data, 32'd0);
      check("x_stray_idle", 32'(idle), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("x_no_req", 32'(ch2_req), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
